// File: rtl/serial_rx_rb2.sv
// serial_rx_rb2
// Receives 21-bit serial column frames (3-bit column address, then 18 data
// bits d[17]..d[0]) into an 18x8 bit-matrix buffer. Once all eight columns
// have been received, the buffer is written out as 18 bytes over the RB2
// write port, followed by a one-cycle done pulse.
//
// Ports
//   clk    : clock, rising-edge active
//   rst    : asynchronous active-low reset
//   sen    : serial enable, active-low (low marks frame bits)
//   sd     : serial data, sampled while sen=0
//   RB2_RW : 1 = read/idle, 0 = write
//   RB2_A  : RB2 word address (0..17)
//   RB2_D  : RB2 write data
//   done   : one-cycle pulse after the 18-word write-out
//   err    : sticky dropped/truncated-frame flag, cleared only by reset
module serial_rx_rb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       sen,
    input  logic       sd,
    output logic       RB2_RW,
    output logic [4:0] RB2_A,
    output logic [7:0] RB2_D,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  mask_q, mask_d;
    logic        armed_q, armed_d;
    logic        err_q, err_d;
    logic [7:0]  buf_q [0:17];
    logic        buf_we_s;
    logic [7:0]  mask_set_s;
    logic [7:0]  row_s;

    logic        rw_q, rw_d;
    logic [4:0]  a_q, a_d;
    logic [7:0]  d_q, d_d;
    logic        done_q, done_d;

    assign mask_set_s = mask_q | (8'd1 << addr_q);

    // Next-state logic for the frame receiver and write-out sequencer.
    // armed_q records that sen has been seen high since the last frame start
    // (or reset); a frame may only start while armed. Low bits arriving while
    // unarmed are the tail of an already-finished frame and are ignored
    // silently, whereas a new frame starting during WRITE/DONE is dropped
    // and flagged.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        armed_d  = sen ? 1'b1 : armed_q;
        err_d    = err_q;
        buf_we_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 5'd0;
                if (!sen && armed_q) begin
                    state_d = S_ADDR;
                    addr_d  = {sd, 2'b00};
                    cnt_d   = 5'd1;
                    armed_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (sen) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = 5'd0;
                end else if (cnt_q == 5'd1) begin
                    addr_d = {addr_q[2], sd, 1'b0};
                    cnt_d  = 5'd2;
                end else begin
                    addr_d  = {addr_q[2:1], sd};
                    cnt_d   = 5'd17;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (sen) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = 5'd0;
                end else begin
                    buf_we_s = 1'b1;
                    if (cnt_q == 5'd0) begin
                        mask_d = mask_set_s;
                        cnt_d  = 5'd0;
                        if (mask_set_s == 8'hFF) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == 5'd17) begin
                    state_d = S_DONE;
                    mask_d  = 8'd0;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
                if (!sen && armed_q) begin
                    err_d   = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    err_d = err_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
                if (!sen && armed_q) begin
                    err_d   = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Registered-output next values, derived from the next state so the first
    // write appears right after the edge that completes the mask. Row 0 may
    // be written on that same edge, hence the bypass of the incoming bit.
    always_comb begin
        row_s = buf_q[cnt_d];
        if (buf_we_s && (cnt_d == cnt_q)) begin
            row_s[3'd7 - addr_q] = sd;
        end else begin
            row_s = buf_q[cnt_d];
        end
        if (state_d == S_WRITE) begin
            rw_d = 1'b0;
            a_d  = cnt_d;
            d_d  = row_s;
        end else begin
            rw_d = 1'b1;
            a_d  = 5'd0;
            d_d  = 8'd0;
        end
        done_d = (state_d == S_DONE);
    end

    // Control state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            addr_q  <= 3'd0;
            mask_q  <= 8'd0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
            rw_q    <= 1'b1;
            a_q     <= 5'd0;
            d_q     <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            armed_q <= armed_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            a_q     <= a_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    // Column buffer: data bit d[k] of column c lands in buf[k][7-c].
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_q[cnt_q][3'd7 - addr_q] <= sd;
        end
    end

    assign RB2_RW = rw_q;
    assign RB2_A  = a_q;
    assign RB2_D  = d_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_serial_rx_rb2.sv
module tb_serial_rx_rb2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sen = 1'b1;
    logic       sd  = 1'b0;
    logic       RB2_RW;
    logic [4:0] RB2_A;
    logic [7:0] RB2_D;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;
    int wr_n     = 0;
    int done_cnt = 0;
    logic [4:0] wa [0:63];
    logic [7:0] wd [0:63];
    logic [7:0] img [0:17];

    serial_rx_rb2 dut (
        .clk(clk), .rst(rst), .sen(sen), .sd(sd),
        .RB2_RW(RB2_RW), .RB2_A(RB2_A), .RB2_D(RB2_D),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Log every RB2 write cycle and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && RB2_RW === 1'b0) begin
            if (wr_n < 64) begin
                wa[wr_n] = RB2_A;
                wd[wr_n] = RB2_D;
            end
            wr_n++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sen = 1'b1;
        sd  = 1'b0;
        repeat (n) tick();
    endtask

    // Drive nbits low-sen cycles: address, data from img (optionally inverted),
    // and ones for any bits beyond the 21st.
    task automatic send_frame(input int col, input int nbits, input logic inv);
        for (int b = 0; b < nbits; b++) begin
            sen = 1'b0;
            if (b < 3) sd = col[2-b];
            else if (b < 21) sd = img[17-(b-3)][7-col] ^ inv;
            else sd = 1'b1;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sen = 1'b1;
        sd  = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        wr_n     = 0;
        done_cnt = 0;
    endtask

    task automatic set_img(input int mul, input int x);
        for (int i = 0; i < 18; i++) img[i] = 8'((i * mul) ^ x);
    endtask

    task automatic wait_done(input string name);
        sen = 1'b1;
        for (int c = 0; c < 60 && done_cnt == 0; c++) tick();
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s_done_timeout got done_cnt=0 want 1", name);
        end
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sen = 1'b1;
        repeat (2) tick();
        total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL reset_rw got %b want 1", RB2_RW); end
        total++; if (RB2_A !== 5'd0) begin bad++; $display("FAIL reset_a got %0d want 0", RB2_A); end
        total++; if (RB2_D !== 8'd0) begin bad++; $display("FAIL reset_d got %0h want 0", RB2_D); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        set_img(17, 0);
        for (int c = 0; c < 7; c++) begin send_frame(c, 21, 1'b0); idle(1); end
        total++; if (wr_n != 0) begin bad++; $display("FAIL basic_early got %0d writes want 0", wr_n); end
        send_frame(7, 21, 1'b0);
        total++;
        if (RB2_RW !== 1'b0 || RB2_A !== 5'd0 || RB2_D !== img[0]) begin
            bad++;
            $display("FAIL basic_first got RW=%b A=%0d D=%02h want RW=0 A=0 D=%02h", RB2_RW, RB2_A, RB2_D, img[0]);
        end
        wait_done("basic");
        total++; if (wr_n != 18) begin bad++; $display("FAIL basic_count got %0d want 18", wr_n); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_donecnt got %0d want 1", done_cnt); end
        total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL basic_rw_after got %b want 1", RB2_RW); end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (wa[i] !== 5'(i) || wd[i] !== img[i]) begin
                bad++;
                $display("FAIL basic_word%0d got A=%0d D=%02h want A=%0d D=%02h", i, wa[i], wd[i], i, img[i]);
            end
        end
    endtask

    task automatic test_order();
        int ord [0:7] = '{7, 3, 0, 5, 1, 6, 2, 4};
        do_reset();
        set_img(13, 8'h03);
        for (int j = 0; j < 7; j++) begin send_frame(ord[j], 21, 1'b0); idle(1); end
        total++; if (wr_n != 0) begin bad++; $display("FAIL order_early got %0d writes want 0", wr_n); end
        send_frame(ord[7], 21, 1'b0);
        wait_done("order");
        total++; if (wr_n != 18) begin bad++; $display("FAIL order_count got %0d want 18", wr_n); end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (wa[i] !== 5'(i) || wd[i] !== img[i]) begin
                bad++;
                $display("FAIL order_word%0d got A=%0d D=%02h want A=%0d D=%02h", i, wa[i], wd[i], i, img[i]);
            end
        end
    endtask

    task automatic test_truncated();
        do_reset();
        set_img(37, 8'h5A);
        for (int c = 0; c < 8; c++) begin
            if (c != 2) begin send_frame(c, 21, 1'b0); idle(1); end
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL trunc_err_before got %b want 0", err); end
        send_frame(2, 13, 1'b1);
        idle(1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL trunc_err got %b want 1", err); end
        total++; if (wr_n != 0) begin bad++; $display("FAIL trunc_early got %0d writes want 0", wr_n); end
        send_frame(2, 21, 1'b0);
        wait_done("trunc");
        total++; if (wr_n != 18) begin bad++; $display("FAIL trunc_count got %0d want 18", wr_n); end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (wa[i] !== 5'(i) || wd[i] !== img[i]) begin
                bad++;
                $display("FAIL trunc_word%0d got A=%0d D=%02h want A=%0d D=%02h", i, wa[i], wd[i], i, img[i]);
            end
        end
    endtask

    task automatic test_long_sen();
        do_reset();
        set_img(29, 8'hC3);
        send_frame(0, 25, 1'b0);
        idle(1);
        for (int c = 1; c < 8; c++) begin send_frame(c, 21, 1'b0); idle(1); end
        wait_done("long");
        total++; if (err !== 1'b0) begin bad++; $display("FAIL long_err got %b want 0", err); end
        total++; if (wr_n != 18) begin bad++; $display("FAIL long_count got %0d want 18", wr_n); end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (wa[i] !== 5'(i) || wd[i] !== img[i]) begin
                bad++;
                $display("FAIL long_word%0d got A=%0d D=%02h want A=%0d D=%02h", i, wa[i], wd[i], i, img[i]);
            end
        end
    endtask

    task automatic test_reset_in_write();
        bit seen = 1'b0;
        do_reset();
        set_img(17, 8'hFF);
        for (int c = 0; c < 8; c++) begin send_frame(c, 21, 1'b0); idle(1); end
        for (int c = 0; c < 40 && !seen; c++) begin
            if (RB2_RW === 1'b0 && RB2_A === 5'd9) seen = 1'b1;
            else tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL rstw_reach got no A=9 want A=9"); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (RB2_RW !== 1'b1) begin bad++; $display("FAIL rstw_rw got %b want 1", RB2_RW); end
        total++; if (RB2_A !== 5'd0) begin bad++; $display("FAIL rstw_a got %0d want 0", RB2_A); end
        repeat (2) tick();
        rst = 1'b1;
        idle(30);
        total++; if (wr_n != 9) begin bad++; $display("FAIL rstw_count got %0d want 9", wr_n); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rstw_done got %0d want 0", done_cnt); end
        wr_n = 0;
        set_img(11, 8'h96);
        for (int c = 0; c < 8; c++) begin send_frame(c, 21, 1'b0); idle(1); end
        wait_done("rstw");
        total++; if (wr_n != 18) begin bad++; $display("FAIL rstw_count2 got %0d want 18", wr_n); end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (wa[i] !== 5'(i) || wd[i] !== img[i]) begin
                bad++;
                $display("FAIL rstw_word%0d got A=%0d D=%02h want A=%0d D=%02h", i, wa[i], wd[i], i, img[i]);
            end
        end
    endtask

    task automatic test_frame_in_write();
        do_reset();
        set_img(19, 8'h24);
        for (int c = 0; c < 7; c++) begin send_frame(c, 21, 1'b0); idle(1); end
        send_frame(7, 21, 1'b0);
        idle(2);
        send_frame(0, 21, 1'b1);
        idle(1);
        wait_done("fiw");
        total++; if (err !== 1'b1) begin bad++; $display("FAIL fiw_err got %b want 1", err); end
        total++; if (wr_n != 18) begin bad++; $display("FAIL fiw_count got %0d want 18", wr_n); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL fiw_donecnt got %0d want 1", done_cnt); end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (wa[i] !== 5'(i) || wd[i] !== img[i]) begin
                bad++;
                $display("FAIL fiw_word%0d got A=%0d D=%02h want A=%0d D=%02h", i, wa[i], wd[i], i, img[i]);
            end
        end
        for (int c = 1; c < 8; c++) begin send_frame(c, 21, 1'b0); idle(1); end
        idle(30);
        total++; if (wr_n != 18) begin bad++; $display("FAIL fiw_mask got %0d writes want 18", wr_n); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_truncated();
        test_long_sen();
        test_reset_in_write();
        test_frame_in_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_rx_rb2.md
SERIAL_RX_RB2 -- requirements
Module: serial_rx_rb2

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have port sen, input, 1 bit: serial enable, active-low; low marks frame bits.
REQ-004 SHALL have port sd, input, 1 bit: serial data, valid on every cycle with sen=0.
REQ-005 SHALL have port RB2_RW, output, 1 bit: RB2 control, 1=read/idle, 0=write.
REQ-006 SHALL have port RB2_A, output, 5 bits: RB2 word address, 0..17 used.
REQ-007 SHALL have port RB2_D, output, 8 bits: RB2 write data.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse after the 18-word write-out completes.
REQ-009 SHALL have port err, output, 1 bit: sticky flag for a dropped or truncated frame, cleared only by reset.

Function
REQ-010 Frame format SHALL be 21 bits, sampled on consecutive rising edges with sen=0: 3-bit column address, MSB first, then 18 data bits d[17] down to d[0].
REQ-011 States SHALL be IDLE, ADDR, DATA, WRITE, DONE, with a 5-bit bit counter and an 18x8 internal buffer buf[0..17].
REQ-012 IDLE->ADDR SHALL occur on the first edge with sen=0, and that edge's sd SHALL be captured as address bit 2.
REQ-013 ADDR SHALL capture address bits 1 and 0 on the next two edges, then go to DATA.
REQ-014 In DATA, the bit received for d[k] SHALL be written to buf[k][7-addr] on the sampling edge; all other buf bits are unchanged.
REQ-015 After d[0] is sampled, column addr SHALL be marked in an 8-bit received mask, and the FSM SHALL return to IDLE.
REQ-016 If the mask becomes 8'hFF, the FSM SHALL go to WRITE instead of IDLE.
REQ-017 Bits with sen=0 after the 21st bit SHALL be ignored until sen returns to 1.
REQ-018 A new frame SHALL be accepted only after at least one cycle with sen=1.
REQ-019 Truncated frame: sen=1 in ADDR or DATA SHALL abandon the frame, leave the mask unchanged, set err, and return to IDLE. Buffer bits already written may remain; a repeat frame overwrites them.
REQ-020 A repeated column address SHALL overwrite that column; the mask bit stays set.
REQ-021 WRITE SHALL take exactly 18 cycles; cycle i (i=0..17) drives RB2_RW=0, RB2_A=i, RB2_D=buf[i].
REQ-022 After the 18th write cycle, the FSM SHALL enter DONE for one cycle with done=1, RB2_RW=1, and the mask cleared, then return to IDLE.
REQ-023 sen=0 during WRITE or DONE SHALL cause the frame to be dropped whole and err set; the FSM SHALL wait for sen=1 before accepting.
REQ-024 Outside WRITE, RB2_RW SHALL be 1, and RB2_A and RB2_D SHALL hold 0.
REQ-025 All outputs SHALL be registered; the first write SHALL appear on the cycle after the edge that sets the final mask bit.

Reset
REQ-026 While rst=0: state=IDLE, counter=0, mask=0, RB2_RW=1, RB2_A=0, RB2_D=0, done=0, err=0; buf contents need not be cleared.
REQ-027 rst asserted mid-frame or mid-WRITE SHALL abort immediately with no further RB2 writes, and a partial frame SHALL not be committed after release.
REQ-028 After release, a frame SHALL be accepted only after sen has been observed at 1 for at least one cycle.

Verification
REQ-029 Eight frames, addr 0..7, with data taken from source bytes S[k]=k*8'h11 -> 18 writes RB2[k]=S[k], k=0..17, addresses in order, then done high for one cycle.
REQ-030 Frames sent in order 7,3,0,5,1,6,2,4 -> same RB2 contents as in order 0..7; write-out starts only after the 8th frame.
REQ-031 Frame addr=2 truncated after 10 data bits, then a full resend -> err=1, correct final RB2 image, exactly 18 writes.
REQ-032 sen held low for 25 cycles -> bits 22..25 ignored; column data matches the first 21 bits.
REQ-033 rst pulsed low during WRITE at i=9 -> RB2_RW=1 immediately, no done; then 8 new frames -> full 18-word write-out.
REQ-034 Frame begins during WRITE -> frame dropped, err=1, write sequence unaltered.
